// File: rtl/watch_pkg.sv
// Shared definitions for the watch controller: mode encoding and field limits.
// Pure definitions, no logic and no latency.
// Header-only; optional blink support is selected by WATCH_BLINK_EN in watch_ctrl.
package watch_pkg;

  // Controller mode, also driven straight out on the mode port
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/watch_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchronizer, stability filter, rising-edge press pulse.
// Latency: press_o rises 2 + DEBOUNCE_CYC clk after a clean key edge, one clk wide.
// No backpressure; a held key yields one pulse only, releases yield none.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Two-stage synchronizer for the asynchronous button level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it differs from the held one for DEBOUNCE_CYC clk
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q   <= sync2_q;
        cnt_q   <= '0;
        press_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/watch_ctrl.sv
// Watch control FSM: RUN time-keeping pulses, SET_* editing, idle timeout to RUN.
// Latency: every pulse output is registered, 1 clk after tick / debounced press.
// No backpressure; counters must accept one pulse per clk. Blink: WATCH_BLINK_EN.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_S    = 30
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] sec_val,
  input  logic [7:0] min_val,
  input  logic [4:0] hour_val,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink_sec,
  output logic       blink_min,
  output logic       blink_hour
);

  localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

  logic              mode_press, inc_press;
  mode_e             mode_q;
  logic [IDLE_W-1:0] idle_q;
  logic              sec_inc_q, min_inc_q, hour_inc_q, sec_clr_q;
  logic              sec_wrap, min_wrap, hour_ok;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_mode (
    .clk_i   (clk),
    .rst_i   (RESET),
    .key_i   (key_mode),
    .press_o (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_inc (
    .clk_i   (clk),
    .rst_i   (RESET),
    .key_i   (key_inc),
    .press_o (inc_press)
  );

  assign sec_wrap = (sec_val == SEC_MAX);
  assign min_wrap = (min_val == MIN_MAX);
  // A carry into hours is suppressed while the hour input reads an illegal value
  assign hour_ok  = (hour_val <= HOUR_MAX);

  // Mode FSM, idle timeout and registered pulse outputs
  always_ff @(posedge clk) begin
    if (RESET) begin
      mode_q     <= RUN;
      idle_q     <= '0;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      sec_clr_q  <= 1'b0;
    end else begin
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      sec_clr_q  <= 1'b0;
      if (mode_q == RUN) begin
        idle_q <= '0;
        if (tick_1hz) begin
          sec_inc_q  <= 1'b1;
          min_inc_q  <= sec_wrap;
          hour_inc_q <= sec_wrap && min_wrap && hour_ok;
        end
        if (mode_press) mode_q <= SET_HOUR;
      end else if (mode_press) begin
        // Mode wins over a simultaneous inc press, which is dropped
        idle_q <= '0;
        case (mode_q)
          SET_HOUR: mode_q <= SET_MIN;
          SET_MIN:  mode_q <= SET_SEC;
          default:  mode_q <= RUN;
        endcase
      end else if (inc_press) begin
        // Edit action; a tick in the same cycle is ignored (time is paused)
        idle_q <= '0;
        case (mode_q)
          SET_HOUR: hour_inc_q <= 1'b1;
          SET_MIN:  min_inc_q  <= 1'b1;
          default:  sec_clr_q  <= 1'b1;
        endcase
      end else if (tick_1hz) begin
        if (idle_q == IDLE_LAST) begin
          mode_q <= RUN;
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign sec_inc  = sec_inc_q;
  assign min_inc  = min_inc_q;
  assign hour_inc = hour_inc_q;
  assign sec_clr  = sec_clr_q;
  assign mode     = mode_q;

`ifdef WATCH_BLINK_EN
  logic blink_q;

  // Blink phase toggles per tick while editing, held low in RUN
  always_ff @(posedge clk) begin
    if (RESET || mode_q == RUN) blink_q <= 1'b0;
    else if (tick_1hz)          blink_q <= ~blink_q;
  end

  assign blink_hour = (mode_q == SET_HOUR) && blink_q;
  assign blink_min  = (mode_q == SET_MIN)  && blink_q;
  assign blink_sec  = (mode_q == SET_SEC)  && blink_q;
`else
  assign blink_hour = 1'b0;
  assign blink_min  = 1'b0;
  assign blink_sec  = 1'b0;
`endif

endmodule

// File: doc/watch_ctrl.md
WATCH_CTRL -- requirements
Module: watch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 16: clk cycles a synchronized key level must stay stable before it is accepted.
REQ-002 Parameter TIMEOUT_S, default 30: ticks with no accepted key press before a set mode returns to RUN.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port RESET, input, 1: reset, synchronous, active-high.
REQ-005 Port tick_1hz, input, 1: one-clk-wide pulse, once per second.
REQ-006 Port key_mode, input, 1: raw, asynchronous MODE button level, active-high.
REQ-007 Port key_inc, input, 1: raw, asynchronous INC button level, active-high.
REQ-008 Port sec_val, input, 8: current seconds count, binary 0..59.
REQ-009 Port min_val, input, 8: current minutes count, binary 0..59.
REQ-010 Port hour_val, input, 5: current hours count, binary 0..23.
REQ-011 Ports sec_inc, min_inc, hour_inc, output, 1 each: one-clk increment pulse to the matching counter.
REQ-012 Port sec_clr, output, 1: one-clk pulse that zeroes the seconds counter.
REQ-013 Port mode, output, 2: current state encoding.
REQ-014 Ports blink_sec, blink_min, blink_hour, output, 1 each: display blank request for the field being edited.

Function
REQ-015 Each key passes a 2-flop synchronizer, then the key_debounce filter; a rising edge of the debounced level gives a one-clk press pulse.
REQ-016 FSM states: RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3; a mode press advances RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
REQ-017 In RUN, each tick_1hz asserts sec_inc in the following cycle.
REQ-018 In RUN, min_inc asserts with that sec_inc only when sec_val==59; hour_inc also asserts only when sec_val==59 and min_val==59.
REQ-019 Wrap to 0 belongs to the counters; watch_ctrl compares against 59 and 23 only.
REQ-020 In every SET state, time is paused: tick_1hz issues no inc pulse.
REQ-021 In SET_HOUR, an inc press gives one hour_inc pulse; in SET_MIN, one min_inc pulse; no carry propagates in either.
REQ-022 In SET_SEC, an inc press gives one sec_clr pulse.
REQ-023 All output pulses are registered, with exactly 1 clk latency from the triggering event.
REQ-024 Mode press and inc press in the same cycle: the mode press is taken and the inc press is discarded.
REQ-025 Tick and inc press in the same cycle in a SET state: only the inc action occurs.
REQ-026 An idle counter counts ticks in SET states; any press clears it; on reaching TIMEOUT_S it forces RUN on the next cycle.
REQ-027 The idle counter is held at 0 while in RUN.
REQ-028 Key held continuously: exactly one press pulse per debounced rising edge; no auto-repeat.

Reset
REQ-029 While RESET=1 at a clk edge: mode=RUN, idle counter=0, synchronizers and debouncers cleared to released, all pulse and blink outputs 0.
REQ-030 Reset mid-set-operation abandons the edit; no pending pulse is emitted after RESET deasserts.

Configuration
REQ-031 Macro WATCH_BLINK_EN defined: a blink phase flop toggles on every tick_1hz while in a SET state and is cleared in RUN.
REQ-032 With WATCH_BLINK_EN defined, the blink_* output of the edited field equals the blink phase flop; the other blink_* outputs are 0.
REQ-033 Macro WATCH_BLINK_EN undefined: all blink_* outputs are tied to 0 and no phase flop exists.

Structure
REQ-034 Package watch_pkg holds the mode encoding typedef and the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
REQ-035 One sub-module, key_debounce (synchronizer plus stability counter plus edge detect), is instantiated once per key.

Verification
REQ-036 RUN with sec_val=59, min_val=59, hour_val=5, one tick -> sec_inc, min_inc and hour_inc all high in the same single cycle.
REQ-037 RUN with sec_val=30, tick -> only sec_inc high for one cycle.
REQ-038 Bouncy key_mode (glitches shorter than 16 cycles, then stable high 20 cycles) -> exactly one transition, RUN->SET_HOUR.
REQ-039 SET_MIN: three inc presses plus ticks -> exactly three min_inc pulses and zero sec_inc pulses.
REQ-040 SET_SEC: 30 ticks with no press -> mode=RUN one cycle after the 30th tick; with WATCH_BLINK_EN, blink_sec toggled on each of those ticks.
REQ-041 Mode and inc pressed in the same cycle in SET_HOUR -> mode=SET_MIN and no hour_inc pulse.
